alu_ctrl_seq: RTL

Registered, parametrised successor to the combinational ALU32BitController: decodes MIPS opcode/funct into the ALU control word in the ID/EX boundary, with a valid/ready handshake, downstream stall hold, pipeline flush, and a multi-cycle busy window for MUL. It sits between the instruction decoder and the ALU/hazard unit. Unknown encodings raise an explicit flag instead of holding the previous control value.

---
 rtl/alu_ctrl_pkg.sv | 67 ++++++
 rtl/alu_ctrl_decode.sv | 58 +++++
 rtl/alu_ctrl_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the registered ALU controller: MIPS opcode/funct
// encodings, ALU control codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_MUL   = 6'b011100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_MUL   = 5'b00010;
  localparam logic [4:0] ALU_AND   = 5'b00100;
  localparam logic [4:0] ALU_ANDI  = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00111;
  localparam logic [4:0] ALU_NOR   = 5'b01000;
  localparam logic [4:0] ALU_XOR   = 5'b01001;
  localparam logic [4:0] ALU_ORI   = 5'b01010;
  localparam logic [4:0] ALU_XORI  = 5'b01011;
  localparam logic [4:0] ALU_SLL   = 5'b01100;
  localparam logic [4:0] ALU_SRL   = 5'b01101;
  localparam logic [4:0] ALU_SLT   = 5'b01111;
  localparam logic [4:0] ALU_SLTI  = 5'b10000;
  localparam logic [4:0] ALU_BEQ   = 5'b10001;
  localparam logic [4:0] ALU_BNE   = 5'b10010;
  localparam logic [4:0] ALU_REGIMM = 5'b10011;
  localparam logic [4:0] ALU_BGTZ  = 5'b10100;
  localparam logic [4:0] ALU_BLEZ  = 5'b10101;
  localparam logic [4:0] ALU_LW    = 5'b11001;
  localparam logic [4:0] ALU_SW    = 5'b11010;
  localparam logic [4:0] ALU_LB    = 5'b11011;
  localparam logic [4:0] ALU_LH    = 5'b11100;
  localparam logic [4:0] ALU_SB    = 5'b11101;
  localparam logic [4:0] ALU_SH    = 5'b11110;
  localparam logic [4:0] ALU_JR    = 5'b11111;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_BUSY
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational MIPS Op/Funct decode into a 5-bit ALU code, an
// illegal-encoding flag and a MUL marker for the sequencer.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] code,
  output logic       illegal,
  output logic       is_mul
);

  // Unknown encodings fall through to ADD with the illegal flag raised.
  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    is_mul  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_SLL:  code = ALU_SLL;
          FN_SRL:  code = ALU_SRL;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          FN_JR:   code = ALU_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_REGIMM: code = ALU_REGIMM;
      OP_BEQ:    code = ALU_BEQ;
      OP_BNE:    code = ALU_BNE;
      OP_BLEZ:   code = ALU_BLEZ;
      OP_BGTZ:   code = ALU_BGTZ;
      OP_ADDI:   code = ALU_ADD;
      OP_SLTI:   code = ALU_SLTI;
      OP_ANDI:   code = ALU_ANDI;
      OP_ORI:    code = ALU_ORI;
      OP_XORI:   code = ALU_XORI;
      OP_LW:     code = ALU_LW;
      OP_SW:     code = ALU_SW;
      OP_LH:     code = ALU_LH;
      OP_SH:     code = ALU_SH;
      OP_LB:     code = ALU_LB;
      OP_SB:     code = ALU_SB;
      OP_MUL: begin
        code   = ALU_MUL;
        is_mul = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller at the ID/EX boundary: valid/ready handshake,
// stall hold, flush, and a counted busy window while a MUL occupies the ALU.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [5:0]        Op,
  input  logic [5:0]        Funct,
  input  logic              Stall_In,
  input  logic              Flush,
  output logic              Out_Valid,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic              Illegal,
  output logic              Busy
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic [4:0] dec_code;
  logic       dec_illegal;
  logic       dec_is_mul;
  logic       accept;

  alu_ctrl_decode u_decode (
    .op      (Op),
    .funct   (Funct),
    .code    (dec_code),
    .illegal (dec_illegal),
    .is_mul  (dec_is_mul)
  );

  assign In_Ready = (state_q == ST_IDLE) && !Stall_In && !Flush;
  assign accept   = In_Valid && In_Ready;

  // Flush wins over everything but reset; the busy counter ignores Stall_In.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    if (Flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && dec_is_mul && (MUL_LAT > 1)) begin
            state_d = ST_MUL_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_MUL_BUSY: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
        ctrl_d    = CTRL_W'(dec_code);
      end else if (!Stall_In) begin
        valid_d   = 1'b0;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign Out_Valid   = valid_q;
  assign Illegal     = illegal_q;
  assign ALU_Control = ctrl_q;
  assign Busy        = (state_q == ST_MUL_BUSY);

endmodule
